scanline_postproc: RTL and testbench
====================================

Name: scanline_postproc

Overview:
- Parametrised output post-processing pipeline for the scan converter output path, clocked by the output pixel clock.
- Takes line-buffer RGB, sync, DE and line/column phase IDs, and produces the final RGB, sync and DE.
- Over the current fixed pipeline it adds:
  - generic input/output colour depth with bit-replication expansion;
  - multiplicative scanline strength;
  - H, V and combined scanline modes;
  - frame-alternating scanlines;
  - a request/acknowledge config handshake that applies new settings only at frame start.

Parameters:
- IN_BITS, 5, input colour bits per channel (1..OUT_BITS).
- OUT_BITS, 8, output colour bits per channel (4..12).
- ID_BITS, 3, width of line_id/col_id; mask widths are 2**ID_BITS.
- SYNC_POL, 0, active level of HSYNC/VSYNC (0 = active low).

Ports:
- PCLK  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- R_in, G_in, B_in  in  IN_BITS each  pixel data.
- HSYNC_in, VSYNC_in, DE_in  in  1 each  timing inputs.
- line_id, col_id  in  ID_BITS each  line and column phase within the multiplied pixel.
- mask_enable  in  1  border mask active for this pixel.
- cfg_mode  in  2  scanline mode: 0 off, 1 H, 2 V, 3 H|V.
- cfg_str  in  8  scanline strength.
- cfg_line_mask  in  2**ID_BITS  line_ids that receive an H scanline.
- cfg_col_mask  in  2**ID_BITS  col_ids that receive a V scanline.
- cfg_alt  in  1  alternate H scanline phase each frame.
- cfg_mask_br  in  4  border mask brightness.
- cfg_req  in  1  config update request (level).
- cfg_ack  out  1  one-cycle pulse: config applied.
- frame_odd  out  1  frame parity.
- R_out, G_out, B_out  out  OUT_BITS each  processed pixel data.
- HSYNC_out, VSYNC_out, DE_out  out  1 each  delayed timing outputs.

Behaviour:
- Reset:
  - all RGB outputs 0; HSYNC_out/VSYNC_out = !SYNC_POL; DE_out 0; cfg_ack 0; frame_odd 0.
  - shadow config: mode 0, str 0, masks 0, alt 0, br 0.
  - all pipeline registers cleared; syncs cleared to !SYNC_POL.
- Latency: exactly 4 PCLK cycles from input to output for RGB, syncs, DE and mask.
  - Stage 1: register inputs and expand colour.
  - Stage 2: select scanline, multiply.
  - Stage 3: subtract.
  - Stage 4: mask and register outputs.
- Expansion: IN_BITS value x is concatenated with itself repeatedly, MSB first, then truncated to OUT_BITS. Example: 5'h10 -> 8'h84. If IN_BITS == OUT_BITS, the value passes through unchanged.
- Frame edge:
  - Occurs when stage-1 VSYNC goes from !SYNC_POL to SYNC_POL.
  - frame_odd toggles on every frame edge, regardless of cfg_alt.
- Config handshake:
  - If cfg_req = 1 in the cycle the frame edge is detected, the shadow registers load all cfg_* inputs, and cfg_ack = 1 in the next cycle only.
  - A request deasserted before a frame edge is discarded with no ack.
  - The requester holds cfg_req and the cfg_* values stable until it sees cfg_ack.
  - cfg_req still high after ack reloads at the next frame edge (continuous tracking allowed).
  - The new config applies to the first pixel entering stage 2 after the load; no pixel ever sees mixed config.
- Scanline selection, using shadow config:
  - eff_line = line_id + (alt & frame_odd), mod 2**ID_BITS.
  - h_hit = mode[0] & cfg_line_mask[eff_line].
  - v_hit = mode[1] & cfg_col_mask[col_id].
  - hit = h_hit | v_hit; a pixel hit by both is attenuated once only.
- Attenuation:
  - y = x - ((x * (str + 1)) >> 8), using a 9-bit factor and an (OUT_BITS+9)-bit product; no overflow or underflow is possible.
  - str = 255 gives y = 0.
  - If not hit, y = x.
- Mask: when the delayed mask_enable is 1, each channel output = {br, zeros} (br in the top 4 bits). Mask overrides scanlines.
- DE_out = 0 does not force RGB to 0; RGB is passed through as computed.
- Reset asserted mid-frame returns to the reset state immediately; a pending request is lost and no ack is issued.

Decomposition:
- Package scanconv_pkg holds:
  - mode constants SCANLINES_OFF/H/V/HV;
  - SYNC_POL default;
  - strength width 8 and mask brightness width 4;
  - a function for replicated expansion.
- Sub-module px_atten (parameters IN_BITS, OUT_BITS): one channel of expand, multiply, subtract over 3 registered stages, instantiated 3 times.
- The top level holds the sync/ID pipeline, frame-edge detect, shadow config, handshake and mask stage.

Test Plan:
- After reset release, mode 0, R_in = 5'h1F, G_in = 5'h10, B_in = 0 -> 4 cycles later R_out 8'hFF, G_out 8'h84, B_out 8'h00; syncs track inputs delayed by 4.
- cfg_req with mode 1, str 127, line_mask 8'h01, held across a VSYNC edge -> cfg_ack pulses exactly once. Afterwards, R_in 5'h1F on line_id 0 -> R_out 8'h80; on line_id 1 -> 8'hFF.
- mode 3, line_mask 8'h01, col_mask 8'h01, str 255, line_id = col_id = 0 -> 8'h00, attenuated once. col_id 0 with line_id 1 -> 8'h00. Both IDs nonzero -> 8'hFF.
- cfg_alt = 1, line_mask 8'h01:
  - even frame: line_id 0 darkened, line_id 7 not;
  - after the next VSYNC edge: frame_odd = 1, line_id 7 darkened (eff_line 0), line_id 0 not.
- cfg_req pulsed for 10 cycles mid-frame then dropped -> no cfg_ack and no config change at the next frame. Separately, cfg_mask_br = 4'hA with mask_enable = 1 (loaded via handshake) -> RGB out 8'hA0 regardless of scanlines.
- reset asserted for 1 cycle mid-frame while a request is pending -> outputs 0, syncs inactive, shadow config cleared, frame_odd 0, no ack issued.

Source files
------------

// File: rtl/scanconv_pkg.sv
// Shared definitions for the scan converter output path.
//   - scanline mode encoding
//   - default sync polarity, strength and mask-brightness widths
//   - bit-replication helper used for colour depth expansion
package scanconv_pkg;

  typedef enum logic [1:0] {
    SCANLINES_OFF = 2'd0,
    SCANLINES_H   = 2'd1,
    SCANLINES_V   = 2'd2,
    SCANLINES_HV  = 2'd3
  } scan_mode_e;

  localparam bit          SYNC_POL_DEFAULT = 1'b0;
  localparam int unsigned STR_BITS         = 8;
  localparam int unsigned BR_BITS          = 4;

  // Replicated expansion: output bit at position msb_pos (0 = MSB) takes input
  // bit (in_bits-1 - msb_pos mod in_bits). Returns the source bit index.
  function automatic int unsigned rep_src_bit(input int unsigned msb_pos,
                                              input int unsigned in_bits);
    return in_bits - 1 - (msb_pos % in_bits);
  endfunction

endpackage

// File: rtl/px_atten.sv
// One colour channel of the post-processing pipeline.
//   Stage 1: register input, expand IN_BITS -> OUT_BITS by bit replication.
//   Stage 2: multiply by the strength factor when the pixel is a scanline hit.
//   Stage 3: subtract the scaled value.
// Ports:
//   PCLK, reset  clock and async active-high reset
//   x_in         raw channel value (captured into stage 1)
//   hit, factor  scanline decision and (str + 1), valid alongside stage 1
//   y_out        attenuated channel value (stage 3 register)
module px_atten
  import scanconv_pkg::*;
#(
  parameter int unsigned IN_BITS  = 5,
  parameter int unsigned OUT_BITS = 8
) (
  input  logic                PCLK,
  input  logic                reset,
  input  logic [IN_BITS-1:0]  x_in,
  input  logic                hit,
  input  logic [8:0]          factor,
  output logic [OUT_BITS-1:0] y_out
);

  localparam int unsigned PW = OUT_BITS + 9;

  logic [OUT_BITS-1:0] x_exp;
  logic [OUT_BITS-1:0] x_s1_q, x_s2_q;
  logic [PW-1:0]       prod_d, prod_s2_q;

  for (genvar g = 0; g < OUT_BITS; g++) begin : g_exp
    assign x_exp[OUT_BITS-1-g] = x_in[rep_src_bit(g, IN_BITS)];
  end

  // Non-hit pixels carry a zero product so stage 3 passes x through.
  assign prod_d = hit ? (PW'(x_s1_q) * PW'(factor)) : '0;

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      x_s1_q    <= '0;
      x_s2_q    <= '0;
      prod_s2_q <= '0;
      y_out     <= '0;
    end else begin
      x_s1_q    <= x_exp;
      x_s2_q    <= x_s1_q;
      prod_s2_q <= prod_d;
      // factor <= 256 so (x*factor)>>8 <= x: no underflow.
      y_out     <= x_s2_q - prod_s2_q[OUT_BITS+7:8];
    end
  end

endmodule

// File: rtl/scanline_postproc.sv
// Output post-processing for the scan converter: colour expansion, scanlines,
// border mask, with a frame-synchronous config handshake. 4-cycle latency.
// Ports:
//   PCLK, reset                      pixel clock, async active-high reset
//   R_in/G_in/B_in                   line-buffer pixel data (IN_BITS)
//   HSYNC_in/VSYNC_in/DE_in          timing inputs
//   line_id/col_id                   phase within the multiplied pixel
//   mask_enable                      border mask for this pixel
//   cfg_*                            requested config, loaded at frame edge
//   cfg_req/cfg_ack                  level request / one-cycle applied pulse
//   frame_odd                        frame parity
//   R_out/G_out/B_out                processed pixel data (OUT_BITS)
//   HSYNC_out/VSYNC_out/DE_out       timing delayed to match pixel data
module scanline_postproc
  import scanconv_pkg::*;
#(
  parameter int unsigned IN_BITS  = 5,
  parameter int unsigned OUT_BITS = 8,
  parameter int unsigned ID_BITS  = 3,
  parameter bit          SYNC_POL = SYNC_POL_DEFAULT
) (
  input  logic                    PCLK,
  input  logic                    reset,
  input  logic [IN_BITS-1:0]      R_in,
  input  logic [IN_BITS-1:0]      G_in,
  input  logic [IN_BITS-1:0]      B_in,
  input  logic                    HSYNC_in,
  input  logic                    VSYNC_in,
  input  logic                    DE_in,
  input  logic [ID_BITS-1:0]      line_id,
  input  logic [ID_BITS-1:0]      col_id,
  input  logic                    mask_enable,
  input  logic [1:0]              cfg_mode,
  input  logic [STR_BITS-1:0]     cfg_str,
  input  logic [(2**ID_BITS)-1:0] cfg_line_mask,
  input  logic [(2**ID_BITS)-1:0] cfg_col_mask,
  input  logic                    cfg_alt,
  input  logic [BR_BITS-1:0]      cfg_mask_br,
  input  logic                    cfg_req,
  output logic                    cfg_ack,
  output logic                    frame_odd,
  output logic [OUT_BITS-1:0]     R_out,
  output logic [OUT_BITS-1:0]     G_out,
  output logic [OUT_BITS-1:0]     B_out,
  output logic                    HSYNC_out,
  output logic                    VSYNC_out,
  output logic                    DE_out
);

  localparam int unsigned MW = 2**ID_BITS;

  // Stage 1..3 timing pipeline
  logic               hs_s1_q, vs_s1_q, de_s1_q, msk_s1_q;
  logic               hs_s2_q, vs_s2_q, de_s2_q, msk_s2_q;
  logic               hs_s3_q, vs_s3_q, de_s3_q, msk_s3_q;
  logic [ID_BITS-1:0] line_s1_q, col_s1_q;
  logic [BR_BITS-1:0] br_s2_q, br_s3_q;

  // Shadow config
  logic [1:0]          mode_q;
  logic [STR_BITS-1:0] str_q;
  logic [MW-1:0]       line_mask_q, col_mask_q;
  logic                alt_q;
  logic [BR_BITS-1:0]  br_q;
  logic                ack_q, frame_odd_q;

  logic               frame_edge, cfg_load;
  logic [ID_BITS-1:0] eff_line;
  logic               h_hit, v_hit, hit;
  logic [8:0]         factor;
  logic [OUT_BITS-1:0] r_y, g_y, b_y, br_px;

  assign frame_edge = (vs_s1_q == SYNC_POL) && (vs_s2_q != SYNC_POL);
  assign cfg_load   = frame_edge && cfg_req;

  // Hit decision and factor come from the shadow registers as the pixel enters
  // stage 2; a load at the same edge only affects the following pixel.
  assign eff_line = line_s1_q + ID_BITS'(alt_q & frame_odd_q);
  assign h_hit    = ((mode_q == SCANLINES_H) || (mode_q == SCANLINES_HV)) && line_mask_q[eff_line];
  assign v_hit    = ((mode_q == SCANLINES_V) || (mode_q == SCANLINES_HV)) && col_mask_q[col_s1_q];
  assign hit      = h_hit | v_hit;
  assign factor   = {1'b0, str_q} + 9'd1;

  // Mask pixel value: br in the top 4 bits, zeros below.
  assign br_px = OUT_BITS'({br_s3_q, 12'h000} >> (16 - OUT_BITS));

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      hs_s1_q <= !SYNC_POL;  vs_s1_q <= !SYNC_POL;  de_s1_q <= 1'b0;  msk_s1_q <= 1'b0;
      hs_s2_q <= !SYNC_POL;  vs_s2_q <= !SYNC_POL;  de_s2_q <= 1'b0;  msk_s2_q <= 1'b0;
      hs_s3_q <= !SYNC_POL;  vs_s3_q <= !SYNC_POL;  de_s3_q <= 1'b0;  msk_s3_q <= 1'b0;
      line_s1_q <= '0;
      col_s1_q  <= '0;
      br_s2_q   <= '0;
      br_s3_q   <= '0;
      HSYNC_out <= !SYNC_POL;
      VSYNC_out <= !SYNC_POL;
      DE_out    <= 1'b0;
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
    end else begin
      hs_s1_q   <= HSYNC_in;
      vs_s1_q   <= VSYNC_in;
      de_s1_q   <= DE_in;
      msk_s1_q  <= mask_enable;
      line_s1_q <= line_id;
      col_s1_q  <= col_id;
      hs_s2_q   <= hs_s1_q;
      vs_s2_q   <= vs_s1_q;
      de_s2_q   <= de_s1_q;
      msk_s2_q  <= msk_s1_q;
      br_s2_q   <= br_q;  // captured with the pixel so a later load cannot leak in
      hs_s3_q   <= hs_s2_q;
      vs_s3_q   <= vs_s2_q;
      de_s3_q   <= de_s2_q;
      msk_s3_q  <= msk_s2_q;
      br_s3_q   <= br_s2_q;
      HSYNC_out <= hs_s3_q;
      VSYNC_out <= vs_s3_q;
      DE_out    <= de_s3_q;
      R_out     <= msk_s3_q ? br_px : r_y;
      G_out     <= msk_s3_q ? br_px : g_y;
      B_out     <= msk_s3_q ? br_px : b_y;
    end
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      mode_q      <= SCANLINES_OFF;
      str_q       <= '0;
      line_mask_q <= '0;
      col_mask_q  <= '0;
      alt_q       <= 1'b0;
      br_q        <= '0;
      ack_q       <= 1'b0;
      frame_odd_q <= 1'b0;
    end else begin
      ack_q <= cfg_load;
      if (frame_edge) frame_odd_q <= ~frame_odd_q;
      if (cfg_load) begin
        mode_q      <= cfg_mode;
        str_q       <= cfg_str;
        line_mask_q <= cfg_line_mask;
        col_mask_q  <= cfg_col_mask;
        alt_q       <= cfg_alt;
        br_q        <= cfg_mask_br;
      end
    end
  end

  assign cfg_ack   = ack_q;
  assign frame_odd = frame_odd_q;

  px_atten #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_atten_r (
    .PCLK(PCLK), .reset(reset), .x_in(R_in), .hit(hit), .factor(factor), .y_out(r_y)
  );
  px_atten #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_atten_g (
    .PCLK(PCLK), .reset(reset), .x_in(G_in), .hit(hit), .factor(factor), .y_out(g_y)
  );
  px_atten #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_atten_b (
    .PCLK(PCLK), .reset(reset), .x_in(B_in), .hit(hit), .factor(factor), .y_out(b_y)
  );

endmodule

// File: tb/tb_scanline_postproc.sv
module tb_scanline_postproc;

  localparam int unsigned IN_BITS  = 5;
  localparam int unsigned OUT_BITS = 8;
  localparam int unsigned ID_BITS  = 3;

  logic                PCLK = 1'b0;
  logic                reset = 1'b1;
  logic [IN_BITS-1:0]  R_in, G_in, B_in;
  logic                HSYNC_in, VSYNC_in, DE_in;
  logic [ID_BITS-1:0]  line_id, col_id;
  logic                mask_enable;
  logic [1:0]          cfg_mode;
  logic [7:0]          cfg_str;
  logic [7:0]          cfg_line_mask, cfg_col_mask;
  logic                cfg_alt;
  logic [3:0]          cfg_mask_br;
  logic                cfg_req;
  logic                cfg_ack, frame_odd;
  logic [OUT_BITS-1:0] R_out, G_out, B_out;
  logic                HSYNC_out, VSYNC_out, DE_out;

  int errors = 0;
  int checks = 0;
  int acks;
  logic fodd_exp = 1'b0;

  always #5 PCLK = ~PCLK;

  scanline_postproc #(
    .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .ID_BITS(ID_BITS), .SYNC_POL(1'b0)
  ) dut (
    .PCLK(PCLK), .reset(reset),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .HSYNC_in(HSYNC_in), .VSYNC_in(VSYNC_in), .DE_in(DE_in),
    .line_id(line_id), .col_id(col_id), .mask_enable(mask_enable),
    .cfg_mode(cfg_mode), .cfg_str(cfg_str), .cfg_line_mask(cfg_line_mask),
    .cfg_col_mask(cfg_col_mask), .cfg_alt(cfg_alt), .cfg_mask_br(cfg_mask_br),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .frame_odd(frame_odd),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .DE_out(DE_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Falling VSYNC (active low) for 3 cycles; counts acks over a 12-cycle window.
  task automatic vsync_pulse(output int n_ack);
    n_ack = 0;
    VSYNC_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (cfg_ack) n_ack++;
      if (i == 2) VSYNC_in = 1'b1;
    end
    fodd_exp = ~fodd_exp;
  endtask

  task automatic load_cfg(input logic [1:0] mode, input logic [7:0] str, input logic [7:0] lm,
                          input logic [7:0] cm, input logic alt, input logic [3:0] br,
                          output int n_ack);
    cfg_mode = mode; cfg_str = str; cfg_line_mask = lm; cfg_col_mask = cm;
    cfg_alt = alt; cfg_mask_br = br; cfg_req = 1'b1;
    vsync_pulse(n_ack);
    cfg_req = 1'b0;
  endtask

  // Drive one pixel and hold it until it reaches the outputs.
  task automatic pixel(input logic [4:0] r, input logic [2:0] ln, input logic [2:0] cl,
                       input logic msk);
    R_in = r; line_id = ln; col_id = cl; mask_enable = msk;
    step(4);
  endtask

  initial begin
    R_in = '0; G_in = '0; B_in = '0;
    HSYNC_in = 1'b1; VSYNC_in = 1'b1; DE_in = 1'b0;
    line_id = '0; col_id = '0; mask_enable = 1'b0;
    cfg_mode = '0; cfg_str = '0; cfg_line_mask = '0; cfg_col_mask = '0;
    cfg_alt = 1'b0; cfg_mask_br = '0; cfg_req = 1'b0;
    step(3);
    check_eq("rst_r", R_out, 8'h00);
    check_eq("rst_hs", HSYNC_out, 1'b1);
    check_eq("rst_vs", VSYNC_out, 1'b1);
    check_eq("rst_de", DE_out, 1'b0);
    check_eq("rst_ack", cfg_ack, 1'b0);
    check_eq("rst_fodd", frame_odd, 1'b0);
    reset = 1'b0;
    step(2);

    // Expansion and exact 4-cycle latency
    R_in = 5'h1F; G_in = 5'h10; B_in = 5'h00; HSYNC_in = 1'b0; DE_in = 1'b1;
    step(3);
    check_eq("lat3_hs", HSYNC_out, 1'b1);
    check_eq("lat3_r", R_out, 8'h00);
    step(1);
    check_eq("lat4_hs", HSYNC_out, 1'b0);
    check_eq("lat4_de", DE_out, 1'b1);
    check_eq("exp_r", R_out, 8'hFF);
    check_eq("exp_g", G_out, 8'h84);
    check_eq("exp_b", B_out, 8'h00);
    HSYNC_in = 1'b1; DE_in = 1'b0;
    step(4);

    // H scanlines at half strength
    load_cfg(2'd1, 8'd127, 8'h01, 8'h00, 1'b0, 4'h0, acks);
    check_eq("ack_once", acks, 1);
    check_eq("fodd_1", frame_odd, fodd_exp);
    pixel(5'h1F, 3'd0, 3'd0, 1'b0);
    check_eq("h_l0_r", R_out, 8'h80);
    check_eq("h_l0_g", G_out, 8'h42);
    pixel(5'h1F, 3'd1, 3'd0, 1'b0);
    check_eq("h_l1_r", R_out, 8'hFF);

    // Combined H|V, full strength
    load_cfg(2'd3, 8'd255, 8'h01, 8'h01, 1'b0, 4'h0, acks);
    check_eq("ack_hv", acks, 1);
    pixel(5'h1F, 3'd0, 3'd0, 1'b0);
    check_eq("hv_00", R_out, 8'h00);
    pixel(5'h1F, 3'd1, 3'd0, 1'b0);
    check_eq("hv_10", R_out, 8'h00);
    pixel(5'h1F, 3'd0, 3'd1, 1'b0);
    check_eq("hv_01", R_out, 8'h00);
    pixel(5'h1F, 3'd1, 3'd1, 1'b0);
    check_eq("hv_11", R_out, 8'hFF);

    // Frame-alternating phase
    load_cfg(2'd1, 8'd255, 8'h01, 8'h00, 1'b1, 4'h0, acks);
    check_eq("ack_alt", acks, 1);
    check_eq("fodd_alt_a", frame_odd, fodd_exp);
    pixel(5'h1F, 3'd7, 3'd0, 1'b0);
    check_eq("alt_odd_l7", R_out, 8'h00);
    pixel(5'h1F, 3'd0, 3'd0, 1'b0);
    check_eq("alt_odd_l0", R_out, 8'hFF);
    vsync_pulse(acks);
    check_eq("noreq_ack", acks, 0);
    check_eq("fodd_alt_b", frame_odd, fodd_exp);
    pixel(5'h1F, 3'd0, 3'd0, 1'b0);
    check_eq("alt_even_l0", R_out, 8'h00);
    pixel(5'h1F, 3'd7, 3'd0, 1'b0);
    check_eq("alt_even_l7", R_out, 8'hFF);

    // Request withdrawn before a frame edge is discarded
    cfg_mode = 2'd0; cfg_line_mask = 8'h00; cfg_alt = 1'b0; cfg_req = 1'b1;
    step(10);
    cfg_req = 1'b0;
    vsync_pulse(acks);
    check_eq("drop_ack", acks, 0);
    check_eq("fodd_drop", frame_odd, fodd_exp);
    pixel(5'h1F, 3'd7, 3'd0, 1'b0);
    check_eq("drop_keep", R_out, 8'h00);

    // Border mask overrides scanlines
    load_cfg(2'd1, 8'd255, 8'h01, 8'h00, 1'b1, 4'hA, acks);
    check_eq("ack_mask", acks, 1);
    G_in = 5'h03; B_in = 5'h1F;
    pixel(5'h1F, 3'd0, 3'd0, 1'b1);
    check_eq("mask_r", R_out, 8'hA0);
    check_eq("mask_g", G_out, 8'hA0);
    check_eq("mask_b", B_out, 8'hA0);
    pixel(5'h1F, 3'd0, 3'd0, 1'b0);
    check_eq("nomask_r", R_out, 8'h00);

    // Mid-frame reset with a pending request
    vsync_pulse(acks);
    check_eq("fodd_pre_rst", frame_odd, 1'b1);
    cfg_mode = 2'd2; cfg_col_mask = 8'hFF; cfg_mask_br = 4'h5; cfg_req = 1'b1;
    HSYNC_in = 1'b0; DE_in = 1'b1;
    step(5);
    reset = 1'b1;
    #1;
    check_eq("mrst_r", R_out, 8'h00);
    check_eq("mrst_hs", HSYNC_out, 1'b1);
    check_eq("mrst_vs", VSYNC_out, 1'b1);
    check_eq("mrst_de", DE_out, 1'b0);
    check_eq("mrst_fodd", frame_odd, 1'b0);
    check_eq("mrst_ack", cfg_ack, 1'b0);
    step(1);
    reset = 1'b0;
    cfg_req = 1'b0; HSYNC_in = 1'b1; DE_in = 1'b0;
    fodd_exp = 1'b0;
    vsync_pulse(acks);
    check_eq("post_rst_ack", acks, 0);
    check_eq("post_rst_fodd", frame_odd, fodd_exp);
    pixel(5'h1F, 3'd7, 3'd0, 1'b0);
    check_eq("shadow_mode_clr", R_out, 8'hFF);
    pixel(5'h1F, 3'd7, 3'd0, 1'b1);
    check_eq("shadow_br_clr", R_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
